// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants for R-type instruction generation.
package rv32_pkg;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  // ALU control codes as produced by the core's control unit
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SRL  = 4'b0011,
    ALU_SRA  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001
  } alu_ctrl_e;

endpackage

// File: rtl/rtype_encode.sv
// Combinational ALU-control-code to RV32I R-type instruction encoder.
module rtype_encode
  import rv32_pkg::*;
(
  input  logic [3:0]  code_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  logic [6:0] funct7;
  logic [2:0] funct3;

  // Map the ALU code to funct7/funct3; codes above AND are flagged illegal
  always_comb begin
    funct7  = FUNCT7_BASE;
    funct3  = FUNCT3_ADD_SUB;
    legal_o = 1'b1;
    case (code_i)
      ALU_ADD:  funct3 = FUNCT3_ADD_SUB;
      ALU_SUB:  begin funct7 = FUNCT7_ALT; funct3 = FUNCT3_ADD_SUB; end
      ALU_SLL:  funct3 = FUNCT3_SLL;
      ALU_SRL:  funct3 = FUNCT3_SRL_SRA;
      ALU_SRA:  begin funct7 = FUNCT7_ALT; funct3 = FUNCT3_SRL_SRA; end
      ALU_SLT:  funct3 = FUNCT3_SLT;
      ALU_SLTU: funct3 = FUNCT3_SLTU;
      ALU_XOR:  funct3 = FUNCT3_XOR;
      ALU_OR:   funct3 = FUNCT3_OR;
      ALU_AND:  funct3 = FUNCT3_AND;
      default:  legal_o = 1'b0;
    endcase
    word_o = legal_o ? {funct7, rs2_i, rs1_i, funct3, rd_i, OPCODE_RTYPE} : '0;
  end

endmodule

// File: rtl/rtype_instr_writer.sv
// Sequential R-type instruction writer: encodes accepted requests and
// streams them into consecutive instruction RAM words until capacity.
module rtype_instr_writer
  import rv32_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_aluCtrl,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              full,
  output logic              err_illegal
);

  localparam int unsigned       CAP_I = (2 ** ADDR_W) - BASE_ADDR;
  localparam logic [ADDR_W:0]   CAP   = (ADDR_W + 1)'(CAP_I);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     count_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                err_q;
  logic [31:0]         enc_word;
  logic                enc_legal;
  logic                accept;

  rtype_encode u_encode (
    .code_i  (req_aluCtrl),
    .rd_i    (req_rd),
    .rs1_i   (req_rs1),
    .rs2_i   (req_rs2),
    .word_o  (enc_word),
    .legal_o (enc_legal)
  );

  assign full      = (state_q == FULL);
  assign req_ready = ~full & ~clear;
  assign accept    = req_valid & req_ready;
  assign count_d   = count_q + 1'b1;

  // Writer FSM with registered RAM write port, count and sticky error.
  // The pointer may roll over after the final write; FULL blocks any use of it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= BASE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      ptr_q   <= BASE;
      count_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        if (enc_legal) begin
          we_q    <= 1'b1;
          addr_q  <= ptr_q;
          wdata_q <= enc_word;
          ptr_q   <= ptr_q + 1'b1;
          count_q <= count_d;
          state_q <= (count_d == CAP) ? FULL : WRITE;
        end else begin
          err_q   <= 1'b1;
          state_q <= IDLE;
        end
      end else if (state_q != FULL) begin
        state_q <= IDLE;
      end
    end
  end

  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign wr_count    = count_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_rtype_instr_writer.sv
// Self-checking bench for rtype_instr_writer: directed scenarios on a
// default instance and a small (ADDR_W=2, BASE_ADDR=1) instance, plus a
// randomized run against a behavioural model.
module tb_rtype_instr_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: default parameters (CAP = 256)
  logic        a_rst_n, a_clear, a_valid, a_ready, a_we, a_full, a_err;
  logic [3:0]  a_code;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_count;
  logic [51:0] a_obs;
  assign a_obs = {a_we, a_addr, a_wdata, a_count, a_full, a_err};

  // Instance B: ADDR_W=2, BASE_ADDR=1 (CAP = 3)
  logic        b_rst_n, b_clear, b_valid, b_ready, b_we, b_full, b_err;
  logic [3:0]  b_code;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;
  logic [39:0] b_obs;
  assign b_obs = {b_we, b_addr, b_wdata, b_count, b_full, b_err};

  rtype_instr_writer dut_a (
    .clk(clk), .reset_n(a_rst_n), .clear(a_clear), .req_valid(a_valid),
    .req_ready(a_ready), .req_aluCtrl(a_code), .req_rd(a_rd),
    .req_rs1(a_rs1), .req_rs2(a_rs2), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .wr_count(a_count), .full(a_full),
    .err_illegal(a_err)
  );

  rtype_instr_writer #(.ADDR_W(2), .BASE_ADDR(1)) dut_b (
    .clk(clk), .reset_n(b_rst_n), .clear(b_clear), .req_valid(b_valid),
    .req_ready(b_ready), .req_aluCtrl(b_code), .req_rd(b_rd),
    .req_rs1(b_rs1), .req_rs2(b_rs2), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .wr_count(b_count), .full(b_full),
    .err_illegal(b_err)
  );

  // Reference encoding from the instruction-set tables
  int f3_tab [10] = '{0, 0, 1, 5, 5, 2, 3, 4, 6, 7};

  function automatic logic [31:0] ref_word(input logic [3:0] c,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rs2);
    logic [6:0] f7;
    logic [2:0] f3;
    f3 = 3'(f3_tab[c]);
    f7 = (c == 4'd1 || c == 4'd4) ? 7'h20 : 7'h00;
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic v, input logic [3:0] c,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    a_valid = v; a_code = c; a_rd = rd; a_rs1 = rs1; a_rs2 = rs2;
  endtask

  task automatic b_req(input logic v, input logic [3:0] c,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    b_valid = v; b_code = c; b_rd = rd; b_rs1 = rs1; b_rs2 = rs2;
  endtask

  task automatic a_reset();
    a_rst_n = 1'b0; a_clear = 1'b0; a_valid = 1'b0;
    tick();
    a_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3);
    b_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3);
    tick(); tick();
    a_valid = 1'b0; b_valid = 1'b0;
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    #1;
    checks++;
    if (a_obs !== {1'b0, 8'd0, 32'd0, 9'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_a_outputs: got %h expected %h", a_obs, 52'd0);
    end
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL reset_a_ready: got %b expected 1", a_ready);
    end
    checks++;
    if (b_obs !== {1'b0, 2'd1, 32'd0, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_b_outputs: got %h expected %h", b_obs,
                         {1'b0, 2'd1, 32'd0, 3'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_add();
    a_reset();
    a_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3);
    tick();
    a_valid = 1'b0;
    checks++;
    if (a_obs !== {1'b1, 8'd0, 32'h003100B3, 9'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_write: got %h expected %h", a_obs,
                         {1'b1, 8'd0, 32'h003100B3, 9'd1, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if ({a_we, a_count} !== {1'b0, 9'd1}) begin
      errors++; $display("FAIL add_strobe_drop: got we=%b cnt=%0d expected we=0 cnt=1", a_we, a_count);
    end
  endtask

  task automatic test_back_to_back();
    a_reset();
    a_req(1'b1, 4'd1, 5'd5, 5'd6, 5'd7);
    tick();
    a_req(1'b1, 4'd4, 5'd8, 5'd9, 5'd10);
    checks++;
    if (a_obs !== {1'b1, 8'd0, 32'h407302B3, 9'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b2b_sub: got %h expected %h", a_obs,
                         {1'b1, 8'd0, 32'h407302B3, 9'd1, 1'b0, 1'b0});
    end
    tick();
    a_valid = 1'b0;
    checks++;
    if (a_obs !== {1'b1, 8'd1, 32'h40A4D433, 9'd2, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b2b_sra: got %h expected %h", a_obs,
                         {1'b1, 8'd1, 32'h40A4D433, 9'd2, 1'b0, 1'b0});
    end
  endtask

  task automatic test_illegal();
    a_reset();
    a_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3);
    tick();
    a_req(1'b1, 4'b1011, 5'd7, 5'd7, 5'd7);
    tick();
    checks++;
    if ({a_we, a_count, a_err} !== {1'b0, 9'd1, 1'b1}) begin
      errors++; $display("FAIL illegal_accept: got we=%b cnt=%0d err=%b expected we=0 cnt=1 err=1",
                         a_we, a_count, a_err);
    end
    a_req(1'b1, 4'd0, 5'd4, 5'd5, 5'd6);
    tick();
    a_valid = 1'b0;
    checks++;
    if (a_obs !== {1'b1, 8'd1, 32'h00628233, 9'd2, 1'b0, 1'b1}) begin
      errors++; $display("FAIL illegal_next_add: got %h expected %h", a_obs,
                         {1'b1, 8'd1, 32'h00628233, 9'd2, 1'b0, 1'b1});
    end
    repeat (3) tick();
    checks++;
    if ({a_we, a_err} !== 2'b01) begin
      errors++; $display("FAIL illegal_sticky: got we=%b err=%b expected we=0 err=1", a_we, a_err);
    end
  endtask

  task automatic test_full_b();
    logic [3:0] codes [3] = '{4'd0, 4'd7, 4'd9};
    logic [31:0] w;
    b_rst_n = 1'b0; b_clear = 1'b0; b_valid = 1'b0;
    tick();
    b_rst_n = 1'b1;
    b_req(1'b1, 4'd15, 5'd1, 5'd1, 5'd1);
    tick();
    checks++;
    if ({b_we, b_count, b_err, b_full} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL full_b_illegal: got we=%b cnt=%0d err=%b full=%b expected 0 0 1 0",
                         b_we, b_count, b_err, b_full);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      b_req(1'b1, codes[i], 5'(i + 1), 5'(i + 2), 5'(i + 3));
      w = ref_word(codes[i], 5'(i + 1), 5'(i + 2), 5'(i + 3));
      #1;
      checks++;
      if (b_ready !== 1'b1) begin
        errors++; $display("FAIL full_b_ready_pre[%0d]: got %b expected 1", i, b_ready);
      end
      tick();
      checks++;
      if (b_obs !== {1'b1, 2'(i + 1), w, 3'(i + 1), (i == 2), 1'b1}) begin
        errors++; $display("FAIL full_b_write[%0d]: got %h expected %h", i, b_obs,
                           {1'b1, 2'(i + 1), w, 3'(i + 1), (i == 2), 1'b1});
      end
    end
    checks++;
    if (b_ready !== 1'b0) begin
      errors++; $display("FAIL full_b_ready_last: got %b expected 0", b_ready);
    end
    tick();
    checks++;
    if ({b_we, b_count, b_full, b_ready} !== {1'b0, 3'd3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL full_b_stall: got we=%b cnt=%0d full=%b ready=%b expected 0 3 1 0",
                         b_we, b_count, b_full, b_ready);
    end
  endtask

  task automatic test_clear_b();
    b_clear = 1'b1;
    b_req(1'b1, 4'd0, 5'd1, 5'd2, 5'd3);
    #1;
    checks++;
    if (b_ready !== 1'b0) begin
      errors++; $display("FAIL clear_b_ready: got %b expected 0", b_ready);
    end
    tick();
    b_clear = 1'b0;
    checks++;
    if ({b_we, b_count, b_full, b_err} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL clear_b_state: got we=%b cnt=%0d full=%b err=%b expected 0 0 0 0",
                         b_we, b_count, b_full, b_err);
    end
    tick();
    b_valid = 1'b0;
    checks++;
    if ({b_we, b_addr, b_wdata, b_count} !== {1'b1, 2'd1, 32'h003100B3, 3'd1}) begin
      errors++; $display("FAIL clear_b_rewrite: got we=%b addr=%0d data=%h cnt=%0d expected 1 1 003100b3 1",
                         b_we, b_addr, b_wdata, b_count);
    end
  endtask

  task automatic test_reset_mid();
    a_reset();
    a_req(1'b1, 4'd2, 5'd3, 5'd4, 5'd5);
    tick();
    a_rst_n = 1'b0;
    tick();
    a_rst_n = 1'b1; a_valid = 1'b0;
    checks++;
    if (a_obs !== 52'd0) begin
      errors++; $display("FAIL reset_mid: got %h expected %h", a_obs, 52'd0);
    end
  endtask

  task automatic test_random();
    int unsigned m_count;
    logic        m_err, e_we, acc;
    logic [7:0]  e_addr;
    logic [31:0] e_wd;
    a_reset();
    m_count = 0; m_err = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    for (int unsigned n = 0; n < 400; n++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      a_code  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                            : 4'($urandom_range(0, 9));
      a_rd = 5'($urandom); a_rs1 = 5'($urandom); a_rs2 = 5'($urandom);
      a_clear = ($urandom_range(0, 39) == 0);
      #1;
      checks++;
      if (a_ready !== (m_count != 256 && !a_clear)) begin
        errors++; $display("FAIL random_ready[%0d]: got %b expected %b", n, a_ready,
                           (m_count != 256 && !a_clear));
      end
      acc = a_valid && !a_clear && (m_count != 256);
      if (a_clear) begin
        m_count = 0; m_err = 1'b0; e_we = 1'b0;
      end else if (acc && a_code < 4'd10) begin
        e_we = 1'b1; e_addr = 8'(m_count);
        e_wd = ref_word(a_code, a_rd, a_rs1, a_rs2);
        m_count++;
      end else begin
        e_we = 1'b0;
        if (acc) m_err = 1'b1;
      end
      tick();
      checks++;
      if (a_we !== e_we || a_count !== 9'(m_count) || a_full !== (m_count == 256) ||
          a_err !== m_err || (e_we && (a_addr !== e_addr || a_wdata !== e_wd))) begin
        errors++;
        $display("FAIL random[%0d]: got we=%b addr=%h data=%h cnt=%0d full=%b err=%b, expected we=%b addr=%h data=%h cnt=%0d full=%b err=%b",
                 n, a_we, a_addr, a_wdata, a_count, a_full, a_err,
                 e_we, e_addr, e_wd, m_count, (m_count == 256), m_err);
      end
    end
    a_valid = 1'b0; a_clear = 1'b0;
  endtask

  initial begin
    a_rst_n = 1'b0; a_clear = 1'b0; b_rst_n = 1'b0; b_clear = 1'b0;
    a_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
    b_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal();
    test_full_b();
    test_clear_b();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
